mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction cache and the data cache.
- Grants whole data-cache block transfers atomically: write-back pairs, refill pairs and flush words are never interleaved with instruction fetches.
- The data cache has priority; a starvation guard bounds how long an instruction fetch can wait.
- Sits between both caches and the RAM model/controller.

Parameters:
- BLOCK_WORDS, 2, words per data-cache block transfer; grant is held until this many words complete.
- MAX_STARVE, 3, consecutive data blocks completed while iREN is pending before the icache is forced to win.
- CNT_W, 2, width of word and starve counters; must satisfy 2**CNT_W > max(BLOCK_WORDS-1, MAX_STARVE).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; low for exactly the ACCESS cycle of its word.
- iload  out  32  ramload forwarded to icache.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; low for exactly the ACCESS cycle of its word.
- dload  out  32  ramload forwarded to dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- bus_err  out  1  one-cycle pulse when ramstate==ERROR under an active grant.

Behaviour:
- Reset values:
  - state=IDLE; word_cnt=0; starve_cnt=0.
  - ramREN=0, ramWEN=0, iwait=1, dwait=1, bus_err=0.
  - ramaddr/ramstore=0 while IDLE.
- States: IDLE, DGRANT, IGRANT. The grant is registered, so arbitration adds one cycle of latency from IDLE.
- Arbitration function ARB, evaluated at IDLE and at every grant release:
  - 1. If iREN and starve_cnt==MAX_STARVE -> IGRANT.
  - 2. Else if dREN|dWEN -> DGRANT.
  - 3. Else if iREN -> IGRANT.
  - 4. Else -> IDLE.
- IDLE:
  - No RAM request; both waits high.
  - Next state = ARB.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both asserted).
  - dwait = ~(ramstate==ACCESS); iwait=1.
  - On an ACCESS cycle:
    - If word_cnt==BLOCK_WORDS-1, release: word_cnt<=0, next=ARB.
    - Otherwise word_cnt<=word_cnt+1 and stay.
  - If dREN|dWEN is low while in DGRANT (aborted/shortened transfer): release immediately; word_cnt<=0, next=ARB; no RAM request that cycle.
  - On a completed block (ACCESS at the last word): if iREN is high, starve_cnt<=starve_cnt+1, saturating at MAX_STARVE.
- IGRANT:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0.
  - iwait = ~(ramstate==ACCESS); dwait=1.
  - Single word per grant: on ACCESS, starve_cnt<=0 and next=ARB.
  - If iREN drops: next=ARB.
- iload and dload always equal ramload; validity is qualified by the corresponding wait.
- ERROR: the grant is held, the word is not counted, the requester's wait stays high, and bus_err pulses. The transfer retries until ACCESS.
- FREE/BUSY: hold the state; the wait stays high.
- A request change mid-word (e.g. dcache switches WB->READ) does not reset word_cnt unless both dREN and dWEN drop.
- The dcache flush sequence (words back-to-back) is re-arbitrated between blocks; the dcache keeps its priority unless the starvation guard fires.
- Reset mid-transfer: immediate return to reset values; the in-flight word is abandoned.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds 32-bit output ports i_grants, d_blocks, contention_cycles.
  - Counters reset to 0 and wrap at 2**32.
  - i_grants increments on each icache ACCESS; d_blocks on each completed data block.
  - contention_cycles increments every cycle in which iREN and (dREN|dWEN) are both high.
- ARB_STATS_EN undefined: ports and logic absent; functional behaviour identical.

Decomposition:
- ramstate_t, word_t (32-bit) and the arbiter state enum arb_state_t belong in the shared cpu_types_pkg.
- One natural sub-module, arb_stats, holds the optional counters and is instantiated only under ARB_STATS_EN.

Test Plan:
- Icache only: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles -> ramREN=1, ramaddr=0x40; iwait low for exactly 1 cycle with iload=ramload; dwait stays 1.
- Simultaneous requests from IDLE: iREN=1, dWEN=1, daddr=0x100 -> DGRANT; two dcache ACCESS words (0x100, 0x104) complete before any icache request reaches RAM; then IGRANT.
- Starvation: dREN held for 4 blocks with iREN=1 -> after the 3rd block the icache wins (starve_cnt==3), then starve_cnt=0 and the dcache resumes.
- Abort: dREN drops after word 0 -> release in that cycle, word_cnt=0, next grant to the pending iREN.
- Error and reset: ramstate=ERROR in DGRANT -> bus_err pulse, dwait=1, word not counted, success on the following ACCESS. Asserting nRST=0 mid-block -> state IDLE, ramREN=ramWEN=0, both waits 1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared bus types for the caches, arbiter and RAM controller
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} arb_state_t;
endpackage

// File: rtl/arb_stats.sv
// arb_stats: wrapping grant/block/contention counters, built only under ARB_STATS_EN
module arb_stats
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_iacc,
  input  logic  i_dblk,
  input  logic  i_cont,
  output word_t o_i_grants,
  output word_t o_d_blocks,
  output word_t o_contention
);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      o_i_grants   <= '0;
      o_d_blocks   <= '0;
      o_contention <= '0;
    end else begin
      o_i_grants   <= o_i_grants + word_t'(i_iacc);
      o_d_blocks   <= o_d_blocks + word_t'(i_dblk);
      o_contention <= o_contention + word_t'(i_cont);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: icache/dcache arbiter for one RAM port; dcache blocks are atomic,
// a starvation guard bounds icache wait. ARB_STATS_EN adds usage counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int BLOCK_WORDS = 2,
  parameter int MAX_STARVE  = 3,
  parameter int CNT_W       = 2
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      bus_err
`ifdef ARB_STATS_EN
  ,
  output word_t     i_grants,
  output word_t     d_blocks,
  output word_t     contention_cycles
`endif
);
  arb_state_t       r_state, w_next;
  logic [CNT_W-1:0] r_word, w_word, r_starve, w_starve;
  logic             w_acc, w_dreq, w_rel, w_last;
  assign w_acc   = ramstate == ACCESS;
  assign w_dreq  = dREN | dWEN;
  assign w_last  = r_word == CNT_W'(BLOCK_WORDS - 1);
  assign iload   = ramload;
  assign dload   = ramload;
  assign bus_err = r_state != IDLE && ramstate == ERROR;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_word   <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_next;
      r_word   <= w_word;
      r_starve <= w_starve;
    end
  end
  // ARB sees the starve count as updated by this cycle's completion
  always_comb begin
    w_word   = r_word;
    w_starve = r_starve;
    w_rel    = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!w_dreq) begin
          w_word = '0;
          w_rel  = 1'b1;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          dwait  = ~w_acc;
          if (w_acc && w_last) begin
            w_word   = '0;
            w_rel    = 1'b1;
            w_starve = (iREN && r_starve != CNT_W'(MAX_STARVE)) ? r_starve + 1'b1 : r_starve;
          end else if (w_acc) w_word = r_word + 1'b1;
        end
      end
      IGRANT: begin
        ramaddr  = iaddr;
        ramREN   = iREN;
        iwait    = ~w_acc;
        w_starve = w_acc ? '0 : r_starve;
        w_rel    = w_acc | ~iREN;
      end
      default: w_rel = 1'b1;
    endcase
    w_next = !w_rel ? r_state :
             (iREN && w_starve == CNT_W'(MAX_STARVE)) ? IGRANT :
             w_dreq ? DGRANT : iREN ? IGRANT : IDLE;
  end
`ifdef ARB_STATS_EN
  arb_stats u_stats (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_iacc      (r_state == IGRANT && w_acc),
    .i_dblk      (r_state == DGRANT && w_dreq && w_acc && w_last),
    .i_cont      (iREN & w_dreq),
    .o_i_grants  (i_grants),
    .o_d_blocks  (d_blocks),
    .o_contention(contention_cycles)
  );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic against a transaction-level owner model
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam int BW = 2, MS = 3;
  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN = 0, dREN = 0, dWEN = 0;
  word_t iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  ramstate_t ramstate = FREE;
  logic iwait, dwait, ramREN, ramWEN, bus_err;
  word_t iload, dload, ramaddr, ramstore;
  int n_cmp = 0, n_err = 0;
  int m_own = 0, m_words = 0, m_starve = 0;
  int m_ig = 0, m_db = 0, m_ct = 0;
`ifdef ARB_STATS_EN
  word_t i_grants, d_blocks, contention_cycles;
`endif

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
`ifdef ARB_STATS_EN
    , .i_grants(i_grants), .d_blocks(d_blocks), .contention_cycles(contention_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // owner: 0 = nobody, 1 = dcache, 2 = icache
  function automatic int pick(int starved);
    if (iREN && starved == MS) return 2;
    if (dREN || dWEN) return 1;
    if (iREN) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_own = 0; m_words = 0; m_starve = 0;
    m_ig = 0; m_db = 0; m_ct = 0;
  endtask

  task automatic check_model();
    bit acc = ramstate == ACCESS;
    bit dreq = dREN || dWEN;
    bit e_ren = 0, e_wen = 0, e_iw = 1, e_dw = 1;
    word_t e_addr = 0, e_store = 0;
    if (m_own == 1) begin
      e_addr = daddr; e_store = dstore;
      if (dreq) begin e_wen = dWEN; e_ren = dREN && !dWEN; e_dw = !acc; end
    end else if (m_own == 2) begin
      e_addr = iaddr; e_ren = iREN; e_iw = !acc;
    end
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iload", iload, ramload);
    chk("dload", dload, ramload);
    chk("bus_err", bus_err, m_own != 0 && ramstate == ERROR);
  endtask

  task automatic advance();
    bit acc = ramstate == ACCESS;
    bit dreq = dREN || dWEN;
    if (!nRST) begin model_reset(); return; end
    if (iREN && dreq) m_ct++;
    if (m_own == 1) begin
      if (!dreq) begin m_words = 0; m_own = pick(m_starve); end
      else if (acc) begin
        m_words++;
        if (m_words == BW) begin
          m_words = 0; m_db++;
          if (iREN && m_starve < MS) m_starve++;
          m_own = pick(m_starve);
        end
      end
    end else if (m_own == 2) begin
      if (acc) begin m_ig++; m_starve = 0; m_own = pick(m_starve); end
      else if (!iREN) m_own = pick(m_starve);
    end else m_own = pick(m_starve);
  endtask

  task automatic cyc();
    #1 check_model();
    @(posedge CLK);
    advance();
    #1;
  endtask

  initial begin
    #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_ramaddr", ramaddr, 0);
    @(posedge CLK); @(posedge CLK); #1 nRST = 1;
    model_reset();
    // icache only, two BUSY cycles then ACCESS
    iREN = 1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hdeadbeef;
    cyc(); cyc(); cyc();
    ramstate = ACCESS; #1;
    chk("ic_ramREN", ramREN, 1);
    chk("ic_ramaddr", ramaddr, 32'h40);
    chk("ic_iwait", iwait, 0);
    chk("ic_iload", iload, 32'hdeadbeef);
    chk("ic_dwait", dwait, 1);
    cyc();
    iREN = 0; ramstate = FREE; #1 chk("ic_iwait_after", iwait, 1);
    cyc();
    // simultaneous requests: dcache block first
    iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h100; dstore = 32'h1234; ramstate = ACCESS;
    #1 chk("sim_idle_wen", ramWEN, 0);
    cyc();
    #1 chk("sim_w0_wen", ramWEN, 1); chk("sim_w0_addr", ramaddr, 32'h100); chk("sim_w0_iwait", iwait, 1);
    cyc();
    daddr = 32'h104; #1 chk("sim_w1_addr", ramaddr, 32'h104); chk("sim_w1_dwait", dwait, 0);
    cyc();
    dWEN = 0; #1 chk("sim_abort_wen", ramWEN, 0); chk("sim_abort_dwait", dwait, 1);
    cyc();
    dREN = 1; daddr = 32'h300;
    #1 chk("sim_ig_addr", ramaddr, 32'h200); chk("sim_ig_iwait", iwait, 0);
    cyc();
    // starvation: three data blocks, then icache forced in
    for (int k = 0; k < 2 * MS; k++) begin
      #1 chk("starve_d_addr", ramaddr, 32'h300);
      cyc();
    end
    #1 chk("starve_i_addr", ramaddr, 32'h200); chk("starve_i_iwait", iwait, 0);
    cyc();
    #1 chk("resume_d_addr", ramaddr, 32'h300); chk("resume_dwait", dwait, 0);
    cyc();
    // abort after word 0 hands the bus to the pending icache
    dREN = 0; #1 chk("abort_dwait", dwait, 1); chk("abort_ren", ramREN, 0);
    cyc();
    dWEN = 1; daddr = 32'h500; #1 chk("abort_next_i", ramaddr, 32'h200);
    cyc();
    // error retry
    iREN = 0; ramstate = ERROR;
    #1 chk("err_pulse", bus_err, 1); chk("err_dwait", dwait, 1); chk("err_addr", ramaddr, 32'h500);
    cyc();
    ramstate = ACCESS; #1 chk("err_retry_dwait", dwait, 0); chk("err_retry_pulse", bus_err, 0);
    cyc(); cyc(); cyc();
    // async reset mid-block
    #2 nRST = 0; model_reset();
    #1 chk("mrst_ren", ramREN, 0); chk("mrst_wen", ramWEN, 0);
    chk("mrst_iwait", iwait, 1); chk("mrst_dwait", dwait, 1); chk("mrst_addr", ramaddr, 0);
    dWEN = 0;
    @(posedge CLK); #1 nRST = 1;
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      iREN = $urandom_range(0, 3) != 0;
      dREN = $urandom_range(0, 2) == 0;
      dWEN = $urandom_range(0, 2) == 0;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = ($urandom_range(0, 1) == 1) ? ACCESS : ramstate_t'($urandom_range(0, 3));
      nRST = $urandom_range(0, 299) != 0;
      if (!nRST) model_reset();
      cyc();
    end
    nRST = 1;
`ifdef ARB_STATS_EN
    chk("stat_i_grants", i_grants, m_ig);
    chk("stat_d_blocks", d_blocks, m_db);
    chk("stat_contention", contention_cycles, m_ct);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
